// File: rtl/ifetch_unit.sv
`timescale 1ns/1ps
// Instruction fetch front end: credit-limited request issue, in-order response
// tagging, DEPTH-entry instruction buffer, and flush draining of in-flight fetches.
module ifetch_unit #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] i_pc_addr,
    input  logic        i_pc_valid,
    output logic        o_pc_stall,
    input  logic        i_flush,
    output logic        o_inst_req,
    output logic [31:0] o_inst_addr,
    input  logic        i_inst_addr_ok,
    input  logic        i_inst_data_ok,
    input  logic [31:0] i_inst_rdata,
    output logic        o_id_valid,
    input  logic        i_id_ready,
    output logic [31:0] o_id_inst,
    output logic [31:0] o_id_pc
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic {RUN, DRAIN} state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [31:0]   r_buf_pc   [DEPTH];
    logic [31:0]   r_buf_inst [DEPTH];
    logic [31:0]   r_tag      [DEPTH];
    logic [PW-1:0] r_buf_wptr, r_buf_rptr, r_tag_wptr, r_tag_rptr;
    logic [CW-1:0] r_occ, r_out, r_discard;
    logic [CW-1:0] w_credit, w_discard_next;
    logic          w_accept, w_drop, w_take, w_buf_push, w_pop;

    assign w_credit    = CW'(DEPTH) - r_occ - r_out;
    assign w_drop      = i_inst_data_ok & (r_discard != '0);
    assign w_take      = i_inst_data_ok & (r_discard == '0) & (r_out != '0);
    assign w_buf_push  = w_take & ~i_flush;
    assign w_pop       = o_id_valid & i_id_ready;
    assign w_accept    = o_inst_req & i_inst_addr_ok;

    assign o_inst_addr = i_pc_addr;
    assign o_id_valid  = (r_occ != '0);
    assign o_id_inst   = r_buf_inst[r_buf_rptr];
    assign o_id_pc     = r_buf_pc[r_buf_rptr];

    always_comb begin
        o_inst_req     = 1'b0;
        o_pc_stall     = 1'b0;
        w_discard_next = r_discard - CW'(w_drop);
        w_state_next   = r_state;

        o_inst_req = i_pc_valid & (r_state == RUN) & (w_credit != '0) & ~i_flush & ~rst;
        o_pc_stall = i_pc_valid & ~w_accept;

        // A response landing in the flush cycle belongs to a discarded fetch too.
        if (i_flush)
            w_discard_next = r_discard - CW'(w_drop) + r_out - CW'(w_take);

        if (w_discard_next != '0)
            w_state_next = DRAIN;
        else
            w_state_next = RUN;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= RUN;
            r_occ      <= '0;
            r_out      <= '0;
            r_discard  <= '0;
            r_buf_wptr <= '0;
            r_buf_rptr <= '0;
            r_tag_wptr <= '0;
            r_tag_rptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_buf_pc[i]   <= '0;
                r_buf_inst[i] <= '0;
                r_tag[i]      <= '0;
            end
        end else begin
            r_state   <= w_state_next;
            r_discard <= w_discard_next;
            if (i_flush) begin
                r_occ      <= '0;
                r_out      <= '0;
                r_buf_wptr <= '0;
                r_buf_rptr <= '0;
                r_tag_wptr <= '0;
                r_tag_rptr <= '0;
            end else begin
                if (w_accept) begin
                    r_tag[r_tag_wptr] <= i_pc_addr;
                    r_tag_wptr        <= r_tag_wptr + PW'(1);
                end
                if (w_buf_push) begin
                    r_buf_pc[r_buf_wptr]   <= r_tag[r_tag_rptr];
                    r_buf_inst[r_buf_wptr] <= i_inst_rdata;
                    r_buf_wptr             <= r_buf_wptr + PW'(1);
                    r_tag_rptr             <= r_tag_rptr + PW'(1);
                end
                if (w_pop)
                    r_buf_rptr <= r_buf_rptr + PW'(1);
                r_occ <= r_occ + CW'(w_buf_push) - CW'(w_pop);
                r_out <= r_out + CW'(w_accept) - CW'(w_buf_push);
            end
        end
    end
endmodule

// File: tb/tb_ifetch_unit.sv
`timescale 1ns/1ps
// Directed bench for ifetch_unit with a one-cycle-latency memory model and
// an expected-instruction scoreboard checked whenever decode consumes an entry.
module tb_ifetch_unit;
    logic        clk = 1'b0;
    logic        rst, pc_valid, flush, addr_ok, data_ok, id_ready;
    logic [31:0] pc_addr, rdata;
    logic        o_pc_stall, o_inst_req, o_id_valid;
    logic [31:0] o_inst_addr, o_id_inst, o_id_pc;

    always #5 clk = ~clk;

    ifetch_unit #(.DEPTH(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .i_pc_addr      (pc_addr),
        .i_pc_valid     (pc_valid),
        .o_pc_stall     (o_pc_stall),
        .i_flush        (flush),
        .o_inst_req     (o_inst_req),
        .o_inst_addr    (o_inst_addr),
        .i_inst_addr_ok (addr_ok),
        .i_inst_data_ok (data_ok),
        .i_inst_rdata   (rdata),
        .o_id_valid     (o_id_valid),
        .i_id_ready     (id_ready),
        .o_id_inst      (o_id_inst),
        .o_id_pc        (o_id_pc)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_acc   = 0;
    int          n_consumed = 0;
    int          a0;
    logic [31:0] mem_q [$];
    logic [63:0] exp_q [$];
    bit          resp_en, stray;
    bit          last_req, last_stall, last_acc;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ 32'hC0DE_5A00;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive memory response, sample, update models, advance.
    task automatic tick();
        logic [63:0] e;
        data_ok = stray | (resp_en & (mem_q.size() > 0));
        rdata   = stray ? 32'hBAD0_BAD0 : ((mem_q.size() > 0) ? word_of(mem_q[0]) : 32'h0);
        #1;
        last_req   = o_inst_req;
        last_stall = o_pc_stall;
        last_acc   = o_inst_req & addr_ok;
        if (o_inst_req) chk("inst_addr", o_inst_addr, pc_addr);
        if (o_id_valid && id_ready) begin
            chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("id_pc", o_id_pc, e[63:32]);
                chk("id_inst", o_id_inst, e[31:0]);
            end
            n_consumed++;
        end
        if (data_ok && !stray && mem_q.size() > 0) void'(mem_q.pop_front());
        if (last_acc) begin
            n_acc++;
            mem_q.push_back(pc_addr);
            exp_q.push_back({pc_addr, word_of(pc_addr)});
        end
        if (flush) exp_q.delete();
        if (rst) begin
            exp_q.delete();
            mem_q.delete();
        end
        @(posedge clk);
        #1;
        if (last_acc) pc_addr = pc_addr + 32'd4;
    endtask

    task automatic drain(input string tag);
        int i = 0;
        pc_valid = 1'b0;
        id_ready = 1'b1;
        resp_en  = 1'b1;
        while ((exp_q.size() > 0 || mem_q.size() > 0) && i < 30) begin
            tick();
            i++;
        end
        chk(tag, 32'(exp_q.size()), 32'd0);
        chk({tag, "_idle"}, 32'(o_id_valid), 32'd0);
    endtask

    initial begin
        rst = 1'b1; pc_valid = 1'b1; flush = 1'b0; addr_ok = 1'b0; id_ready = 1'b0;
        pc_addr = 32'h0; data_ok = 1'b0; rdata = 32'h0; resp_en = 1'b0; stray = 1'b0;
        @(posedge clk); #1;
        tick();
        chk("rst_stall", 32'(last_stall), 32'd1);
        chk("rst_req", 32'(last_req), 32'd0);
        rst = 1'b0; pc_valid = 1'b0;
        #1;
        chk("reset_id_valid", 32'(o_id_valid), 32'd0);
        chk("reset_id_inst", o_id_inst, 32'h0);
        chk("reset_id_pc", o_id_pc, 32'h0);
        chk("reset_req", 32'(o_inst_req), 32'd0);
        chk("reset_stall", 32'(o_pc_stall), 32'd0);

        // Streaming
        pc_addr = 32'h0; addr_ok = 1'b1; resp_en = 1'b1; id_ready = 1'b1; pc_valid = 1'b1;
        a0 = n_acc; n_consumed = 0;
        for (int i = 0; i < 40 && n_consumed < 6; i++) begin
            if (n_acc - a0 >= 6) pc_valid = 1'b0;
            tick();
        end
        chk("stream_count", 32'(n_consumed), 32'd6);
        drain("stream_drain");

        // Backpressure
        id_ready = 1'b0; pc_addr = 32'h40; pc_valid = 1'b1; a0 = n_acc;
        repeat (6) tick();
        chk("bp_accepts", 32'(n_acc - a0), 32'd2);
        chk("bp_req_low", 32'(last_req), 32'd0);
        chk("bp_stall", 32'(last_stall), 32'd1);
        chk("bp_full_valid", 32'(o_id_valid), 32'd1);
        id_ready = 1'b1;
        tick();
        id_ready = 1'b0; a0 = n_acc;
        repeat (4) tick();
        chk("bp_one_more", 32'(n_acc - a0), 32'd1);
        drain("bp_drain");

        // Flush with two in flight
        resp_en = 1'b0; addr_ok = 1'b1; id_ready = 1'b1; pc_addr = 32'h10; pc_valid = 1'b1;
        a0 = n_acc;
        tick(); tick();
        chk("fl_two_out", 32'(n_acc - a0), 32'd2);
        pc_addr = 32'h80; flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fl_no_req", 32'(last_req), 32'd0);
        tick();
        chk("drain_hold_req", 32'(last_req), 32'd0);
        chk("drain_stall", 32'(last_stall), 32'd1);
        resp_en = 1'b1;
        tick();
        chk("drop1_req", 32'(last_req), 32'd0);
        chk("drop1_valid", 32'(o_id_valid), 32'd0);
        tick();
        chk("drop2_req", 32'(last_req), 32'd0);
        chk("drop2_valid", 32'(o_id_valid), 32'd0);
        tick();
        chk("redirect_req", 32'(last_req), 32'd1);
        drain("fl_drain");

        // Flush with two buffered, none in flight
        id_ready = 1'b0; resp_en = 1'b1; addr_ok = 1'b1; pc_addr = 32'h100; pc_valid = 1'b1;
        a0 = n_acc;
        repeat (4) tick();
        chk("fb_accepts", 32'(n_acc - a0), 32'd2);
        chk("fb_full_valid", 32'(o_id_valid), 32'd1);
        pc_addr = 32'h200; flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fb_flush_noreq", 32'(last_req), 32'd0);
        chk("fb_id_valid", 32'(o_id_valid), 32'd0);
        tick();
        chk("fb_req_next", 32'(last_req), 32'd1);
        drain("fb_drain");

        // Accept+response, then push+pop in the same cycle
        id_ready = 1'b0; resp_en = 1'b1; addr_ok = 1'b1; pc_addr = 32'h400; pc_valid = 1'b1;
        a0 = n_acc;
        tick(); tick();
        chk("sim_accepts", 32'(n_acc - a0), 32'd2);
        id_ready = 1'b1;
        tick();
        chk("sim_valid", 32'(o_id_valid), 32'd1);
        chk("sim_head_pc", o_id_pc, 32'h404);
        chk("sim_head_inst", o_id_inst, word_of(32'h404));
        drain("sim_drain");

        // Reset with one in flight and one buffered
        id_ready = 1'b0; resp_en = 1'b1; addr_ok = 1'b1; pc_addr = 32'h300; pc_valid = 1'b1;
        a0 = n_acc;
        tick(); tick();
        resp_en = 1'b0;
        chk("rr_accepts", 32'(n_acc - a0), 32'd2);
        chk("rr_valid", 32'(o_id_valid), 32'd1);
        rst = 1'b1;
        tick();
        chk("rr_stall", 32'(last_stall), 32'd1);
        chk("rr_req", 32'(last_req), 32'd0);
        rst = 1'b0; pc_valid = 1'b0;
        #1;
        chk("rr_id_valid", 32'(o_id_valid), 32'd0);
        chk("rr_inst_req", 32'(o_inst_req), 32'd0);
        stray = 1'b1;
        tick();
        stray = 1'b0;
        chk("stray_ignored", 32'(o_id_valid), 32'd0);
        resp_en = 1'b1; id_ready = 1'b1; addr_ok = 1'b1; pc_addr = 32'h500; pc_valid = 1'b1;
        a0 = n_acc; n_consumed = 0;
        for (int i = 0; i < 20 && (n_acc - a0) < 2; i++) tick();
        drain("post_rst_drain");
        chk("post_rst_count", 32'(n_consumed), 32'd2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
